// File: rtl/pipe_mult_pkg.sv
// Shared sizing helpers for the pipelined signed Booth multiplier.
package pipe_mult_pkg;

  localparam int MULT_MAX_PIPE = 4;

  // Full signed product width.
  function automatic int mult_prod_w(input int w1, input int w2);
    return w1 + w2;
  endfunction

  // LSB of the kept slice when the result is narrower than the product.
  function automatic int mult_slice_lo(input int w1, input int w2, input int dw);
    return w1 + w2 - dw;
  endfunction

  // Radix-4 Booth partial-product count: ceil((w2+1)/2).
  function automatic int mult_npp(input int w2);
    return (w2 + 2) / 2;
  endfunction

endpackage

// File: rtl/pipe_mult_booth_pp_gen.sv
// Radix-4 Booth recoding of datab; emits sign-extended, pre-shifted partial
// products of dataa, each a full product width wide.
module booth_pp_gen
  import pipe_mult_pkg::*;
#(
  parameter int di1 = 16,
  parameter int di2 = 16,
  localparam int NPP = mult_npp(di2),
  localparam int PW  = mult_prod_w(di1, di2)
) (
  input  logic [di1-1:0]          dataa_i,
  input  logic [di2-1:0]          datab_i,
  output logic [NPP-1:0][PW-1:0]  pp_o
);

  logic [2*NPP:0] bx;
  logic [PW-1:0]  a1, a2, mag;

  // Sign-extend datab to an even width and append the implicit b[-1] = 0.
  assign bx = {(2*NPP)'($signed(datab_i)), 1'b0};
  assign a1 = PW'($signed(dataa_i));
  assign a2 = a1 << 1;

  always_comb begin
    pp_o = '0;
    mag  = '0;
    for (int i = 0; i < NPP; i++) begin
      case (bx[2*i +: 3])
        3'b001, 3'b010, 3'b101, 3'b110: mag = a1;
        3'b011, 3'b100:                 mag = a2;
        default:                        mag = '0;
      endcase
      // Top bit of the triplet marks a negative digit (111 is zero anyway).
      if (bx[2*i+2]) mag = -mag;
      pp_o[i] = mag << (2*i);
    end
  end

endmodule

// File: rtl/pipe_mult.sv
// Fully pipelined signed multiplier: Booth partial products, optional
// adder-tree levels, then a registered result with width fix-up.
module pipe_mult
  import pipe_mult_pkg::*;
#(
  parameter int di1      = 16,
  parameter int di2      = 16,
  parameter int dow      = 32,
  parameter int pipeline = 2
) (
  input  logic           clk1,
  input  logic           rst,
  input  logic [di1-1:0] dataa,
  input  logic [di2-1:0] datab,
  output logic [dow-1:0] result
);

  localparam int PW   = mult_prod_w(di1, di2);
  localparam int NPP  = mult_npp(di2);
  localparam int PIPE = (pipeline > MULT_MAX_PIPE) ? MULT_MAX_PIPE : pipeline;
  localparam int NMID = (PIPE >= 3) ? PIPE - 2 : 0;

  logic [NPP-1:0][PW-1:0] pp, tree_out;
  logic [PW-1:0]          prod;
  logic [dow-1:0]         result_d;

  booth_pp_gen #(.di1(di1), .di2(di2)) u_booth (
    .dataa_i (dataa),
    .datab_i (datab),
    .pp_o    (pp)
  );

  if (PIPE >= 2) begin : g_staged
    // Level 0 holds the partial products; each further level sums pairs.
    logic [NMID:0][NPP-1:0][PW-1:0] lvl_d, lvl_q;

    always_comb begin
      lvl_d    = '0;
      lvl_d[0] = pp;
      for (int m = 1; m <= NMID; m++)
        for (int i = 0; i < NPP; i++)
          lvl_d[m][i/2] = lvl_d[m][i/2] + lvl_q[m-1][i];
    end

    always_ff @(posedge clk1) begin
      if (rst) lvl_q <= '0;
      else     lvl_q <= lvl_d;
    end

    assign tree_out = lvl_q[NMID];
  end else begin : g_flat
    assign tree_out = pp;
  end

  always_comb begin
    prod = '0;
    for (int i = 0; i < NPP; i++) prod = prod + tree_out[i];
  end

  if (dow >= PW) begin : g_sext
    assign result_d = dow'($signed(prod));
  end else begin : g_trunc
    localparam int SLO = mult_slice_lo(di1, di2, dow);
    assign result_d = dow'(prod >> SLO);
  end

  if (PIPE >= 1) begin : g_oreg
    logic [dow-1:0] result_q;
    always_ff @(posedge clk1) begin
      if (rst) result_q <= '0;
      else     result_q <= result_d;
    end
    assign result = result_q;
  end else begin : g_comb
    assign result = result_d;
  end

endmodule

// File: tb/tb_pipe_mult.sv
// Directed and streaming checks of pipe_mult across latency and width variants.
module tb_pipe_mult;

  logic        clk1 = 1'b0;
  logic        rst  = 1'b1;
  logic [15:0] dataa = '0, datab = '0;
  logic [7:0]  a8  = '0;
  logic [11:0] b12 = '0;
  logic [31:0] r0, r1, r2, r3, r4;
  logic [15:0] rw8;
  logic [39:0] rw40;

  int n_chk = 0;
  int n_err = 0;

  // Expected product of the operands currently driven, and its delayed copies.
  logic [31:0] cur_exp = '0;
  logic [31:0] dl [1:4];

  always #5 clk1 = ~clk1;

  pipe_mult #(.pipeline(0)) u_p0 (.clk1(clk1), .rst(rst), .dataa(dataa), .datab(datab), .result(r0));
  pipe_mult #(.pipeline(1)) u_p1 (.clk1(clk1), .rst(rst), .dataa(dataa), .datab(datab), .result(r1));
  pipe_mult                 u_p2 (.clk1(clk1), .rst(rst), .dataa(dataa), .datab(datab), .result(r2));
  pipe_mult #(.pipeline(3)) u_p3 (.clk1(clk1), .rst(rst), .dataa(dataa), .datab(datab), .result(r3));
  pipe_mult #(.pipeline(4)) u_p4 (.clk1(clk1), .rst(rst), .dataa(dataa), .datab(datab), .result(r4));
  pipe_mult #(.di1(8), .di2(12), .dow(16)) u_w8 (.clk1(clk1), .rst(rst), .dataa(a8), .datab(b12), .result(rw8));
  pipe_mult #(.dow(40)) u_w40 (.clk1(clk1), .rst(rst), .dataa(dataa), .datab(datab), .result(rw40));

  always @(posedge clk1) begin
    if (rst) begin
      for (int j = 1; j <= 4; j++) dl[j] <= '0;
    end else begin
      dl[1] <= cur_exp;
      for (int j = 2; j <= 4; j++) dl[j] <= dl[j-1];
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_pipes(input string tag);
    chk({tag, "/p0"}, 64'(r0), 64'(cur_exp));
    chk({tag, "/p1"}, 64'(r1), 64'(dl[1]));
    chk({tag, "/p2"}, 64'(r2), 64'(dl[2]));
    chk({tag, "/p3"}, 64'(r3), 64'(dl[3]));
    chk({tag, "/p4"}, 64'(r4), 64'(dl[4]));
  endtask

  task automatic drive(input string tag, input logic [15:0] a, input logic [15:0] b,
                       input logic [31:0] e, input logic r);
    @(posedge clk1); #1;
    dataa = a; datab = b; cur_exp = e; rst = r;
    @(negedge clk1);
    check_pipes(tag);
  endtask

  logic [15:0] va [10] = '{16'h7FFF, 16'h8000, 16'h8000, 16'hFFFF, 16'h0000,
                           16'h0003, 16'h0100, 16'h7FFF, 16'hFFFF, 16'h1234};
  logic [15:0] vb [10] = '{16'h7FFF, 16'h8000, 16'h7FFF, 16'h0001, 16'h1234,
                           16'hFFFE, 16'h0100, 16'h8000, 16'hFFFF, 16'h0010};
  logic [31:0] ve [10] = '{32'h3FFF0001, 32'h40000000, 32'hC0008000, 32'hFFFFFFFF, 32'h00000000,
                           32'hFFFFFFFA, 32'h00010000, 32'hC0008000, 32'h00000001, 32'h00012340};

  initial begin
    logic [15:0] ra, rb;
    int sa, sb;

    // Reset with nonzero operands: registered variants must read 0.
    drive("rst", 16'h1234, 16'h5678, 32'h06260060, 1'b1);
    drive("rst", 16'h1234, 16'h5678, 32'h06260060, 1'b1);
    chk("rst_p2_zero", 64'(r2), 64'h0);
    chk("rst_p4_zero", 64'(r4), 64'h0);

    // Back-to-back directed vectors; p2 also checked straight from the table.
    for (int k = 0; k < 10; k++) begin
      drive("dir", va[k], vb[k], ve[k], 1'b0);
      if (k >= 2) chk("dir_lat2", 64'(r2), 64'(ve[k-2]));
    end
    for (int k = 0; k < 4; k++) drive("flush", 16'h0000, 16'h0000, 32'h0, 1'b0);

    // One-cycle reset with products in flight.
    drive("mid", 16'h0002, 16'h0003, 32'h00000006, 1'b0);
    drive("mid", 16'h0004, 16'h0005, 32'h00000014, 1'b0);
    drive("mid", 16'h0006, 16'h0007, 32'h0000002A, 1'b1);
    drive("mid", 16'h0008, 16'h0009, 32'h00000048, 1'b0);
    chk("mid_zero0", 64'(r2), 64'h0);
    drive("mid", 16'hFFFE, 16'h0010, 32'hFFFFFFE0, 1'b0);
    chk("mid_zero1", 64'(r2), 64'h0);
    drive("mid", 16'h0000, 16'h0000, 32'h0, 1'b0);
    chk("mid_first", 64'(r2), 64'h48);
    drive("mid", 16'h0000, 16'h0000, 32'h0, 1'b0);
    chk("mid_second", 64'(r2), 64'hFFFFFFE0);

    // Streaming random operands against the delayed reference product.
    for (int k = 0; k < 10000; k++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      sa = $signed(ra);
      sb = $signed(rb);
      drive("rnd", ra, rb, 32'(sa * sb), 1'b0);
    end

    // Width variants: truncation to the upper bits and sign extension.
    a8 = 8'h80; b12 = 12'h7FF;
    for (int k = 0; k < 3; k++) drive("w", 16'hFFFF, 16'h0002, 32'hFFFFFFFE, 1'b0);
    chk("w8_trunc", 64'(rw8), 64'hC008);
    chk("w40_sext", 64'(rw40), 64'hFF_FFFF_FFFE);
    a8 = 8'h7F; b12 = 12'h800;
    for (int k = 0; k < 3; k++) drive("w", 16'h7FFF, 16'h7FFF, 32'h3FFF0001, 1'b0);
    chk("w8_trunc2", 64'(rw8), 64'hC080);
    chk("w40_pos", 64'(rw40), 64'h00_3FFF_0001);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
